// File: rtl/frame_capture_packer_if.sv
// Pixel-stream input and frame-RAM write/status bundle for frame_capture_packer.
// The packer connects through the slave modport; the pixel source and RAM side use master.
interface frame_capture_packer_if #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned ADDR  = 16
);
  logic              capture_start_in;
  logic              frame_valid_in;
  logic              pixel_valid_in;
  logic [PIX_W-1:0]  pixel_data_in;
  logic [ADDR-1:0]   wr_addr_out;
  logic [31:0]       wr_data_out;
  logic              wr_en_out;
  logic              busy_out;
  logic              done_out;
  logic              overflow_out;
  logic [ADDR-1:0]   word_count_out;

  modport master (
    output capture_start_in, frame_valid_in, pixel_valid_in, pixel_data_in,
    input  wr_addr_out, wr_data_out, wr_en_out, busy_out, done_out, overflow_out,
    input  word_count_out
  );

  modport slave (
    input  capture_start_in, frame_valid_in, pixel_valid_in, pixel_data_in,
    output wr_addr_out, wr_data_out, wr_en_out, busy_out, done_out, overflow_out,
    output word_count_out
  );
endinterface

// File: rtl/frame_capture_packer.sv
// Captures one camera frame on request, packing 8-bit pixels little-endian into 32-bit words
// written to the frame RAM from address 0, with saturating word count and sticky overflow.
module frame_capture_packer #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned DEPTH = 16000,
  parameter int unsigned ADDR  = 16
) (
  input logic                   clk,
  input logic                   rst,
  frame_capture_packer_if.slave bus
);

  localparam logic [ADDR-1:0] DepthW = ADDR'(DEPTH);

  typedef enum logic [2:0] {StIdle, StArmed, StCapture, StFlush, StDone} state_e;

  state_e           state_q, state_d;
  logic             seen_low_q, seen_low_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      sr_q, sr_d;
  logic [ADDR-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             wr_en_q, wr_en_d;
  logic [ADDR-1:0]  wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic [31:0]      merged;
  logic             commit;
  logic [31:0]      commit_word;
  logic             full;

  assign full = (count_q == DepthW);

  always_comb begin
    state_d     = state_q;
    seen_low_d  = seen_low_q;
    idx_d       = idx_q;
    sr_d        = sr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    commit      = 1'b0;
    commit_word = sr_q;
    merged      = sr_q;
    merged[idx_q*PIX_W +: PIX_W] = bus.pixel_data_in;

    // The count lags the write strobe by one edge so the strobe cycle shows the old address.
    if (wr_en_q) count_d = count_q + ADDR'(1);

    case (state_q)
      StIdle, StDone: begin
        if (bus.capture_start_in) begin
          state_d    = StArmed;
          seen_low_d = 1'b0;
          idx_d      = 2'd0;
          sr_d       = '0;
          count_d    = '0;
          ovf_d      = 1'b0;
        end
      end
      StArmed: begin
        // A frame already running at arm time must end before capture may begin.
        if (!bus.frame_valid_in) seen_low_d = 1'b1;
        else if (seen_low_q)     state_d    = StCapture;
      end
      StCapture: begin
        if (!bus.frame_valid_in) begin
          if (idx_q != 2'd0) begin
            commit      = 1'b1;
            commit_word = sr_q;
            idx_d       = 2'd0;
            sr_d        = '0;
            state_d     = StFlush;
          end else begin
            state_d = StDone;
          end
        end else if (bus.pixel_valid_in) begin
          if (idx_q == 2'd3) begin
            commit      = 1'b1;
            commit_word = merged;
            sr_d        = '0;
          end else begin
            sr_d = merged;
          end
          idx_d = idx_q + 2'd1;
        end
      end
      StFlush: state_d = StDone;
      default: state_d = StIdle;
    endcase

    if (commit) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = count_q;
        wr_data_d = commit_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      seen_low_q <= 1'b0;
      idx_q      <= 2'd0;
      sr_q       <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      seen_low_q <= seen_low_d;
      idx_q      <= idx_d;
      sr_q       <= sr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.wr_en_out      = wr_en_q;
  assign bus.wr_addr_out    = wr_addr_q;
  assign bus.wr_data_out    = wr_data_q;
  assign bus.word_count_out = count_q;
  assign bus.overflow_out   = ovf_q;
  assign bus.busy_out       = (state_q == StArmed) || (state_q == StCapture) ||
                              (state_q == StFlush);
  assign bus.done_out       = (state_q == StDone);

endmodule

// File: tb/tb_frame_capture_packer.sv
// Directed bench for frame_capture_packer: a full-size instance and a DEPTH=4 instance share
// one stimulus; RAM writes of each are logged at the clock edge that would store them.
module tb_frame_capture_packer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       capture_start = 1'b0;
  logic       frame_valid = 1'b0;
  logic       pixel_valid = 1'b0;
  logic [7:0] pixel_data = 8'h00;

  always #5 clk = ~clk;

  frame_capture_packer_if #(.PIX_W(8), .ADDR(16)) bus ();
  frame_capture_packer_if #(.PIX_W(8), .ADDR(16)) sbus ();

  assign bus.capture_start_in  = capture_start;
  assign bus.frame_valid_in    = frame_valid;
  assign bus.pixel_valid_in    = pixel_valid;
  assign bus.pixel_data_in     = pixel_data;
  assign sbus.capture_start_in = capture_start;
  assign sbus.frame_valid_in   = frame_valid;
  assign sbus.pixel_valid_in   = pixel_valid;
  assign sbus.pixel_data_in    = pixel_data;

  frame_capture_packer #(.PIX_W(8), .DEPTH(16000), .ADDR(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  frame_capture_packer #(.PIX_W(8), .DEPTH(4), .ADDR(16)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  logic [15:0] wa[$];
  logic [31:0] wd[$];
  int unsigned we[$];
  logic [15:0] sa[$];
  logic [31:0] sd[$];
  int unsigned p4[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.wr_en_out) begin
      wa.push_back(bus.wr_addr_out);
      wd.push_back(bus.wr_data_out);
      we.push_back(cyc);
    end
    if (sbus.wr_en_out) begin
      sa.push_back(sbus.wr_addr_out);
      sd.push_back(sbus.wr_data_out);
    end
  end

  task automatic clear_logs();
    wa.delete(); wd.delete(); we.delete();
    sa.delete(); sd.delete(); p4.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      capture_start = 1'b0;
      pixel_valid   = 1'b0;
    end
  endtask

  task automatic arm();
    @(negedge clk);
    capture_start = 1'b1;
    @(negedge clk);
    capture_start = 1'b0;
  endtask

  // Pixels are base, base+1, ...; the last driven cycle pairs a pixel strobe with frame end.
  task automatic run_frame(input logic [7:0] base, input int n, input bit gaps);
    @(negedge clk);
    frame_valid = 1'b1;
    pixel_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat (i % 4) begin
          @(negedge clk);
          pixel_valid = 1'b0;
        end
      end
      @(negedge clk);
      pixel_valid = 1'b1;
      pixel_data  = base + 8'(i);
      if (i % 4 == 3) p4.push_back(cyc);
    end
    @(negedge clk);
    frame_valid = 1'b0;
    pixel_valid = 1'b1;
    pixel_data  = 8'hEE;
    idle(4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.wr_en_out, bus.busy_out, bus.done_out, bus.overflow_out} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000",
               {bus.wr_en_out, bus.busy_out, bus.done_out, bus.overflow_out});
    end
    checks++;
    if ({bus.wr_addr_out, bus.wr_data_out, bus.word_count_out} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data addr %h data %h count %h want all 0",
               bus.wr_addr_out, bus.wr_data_out, bus.word_count_out);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    logic [31:0] exp_d[2];
    exp_d[0] = 32'h04030201;
    exp_d[1] = 32'h08070605;
    clear_logs();
    arm();
    checks++;
    if (bus.busy_out !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_armed got %b want 1", bus.busy_out);
    end
    run_frame(8'h01, 8, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (k >= wa.size()) begin
        errors++;
        $display("FAIL basic_write%0d missing want addr %0d data %h", k, k, exp_d[k]);
      end else if (wa[k] !== 16'(k) || wd[k] !== exp_d[k]) begin
        errors++;
        $display("FAIL basic_write%0d got addr %0d data %h want addr %0d data %h",
                 k, wa[k], wd[k], k, exp_d[k]);
      end
    end
    checks++;
    if (bus.done_out !== 1'b1 || bus.busy_out !== 1'b0 || bus.word_count_out !== 16'd2) begin
      errors++;
      $display("FAIL basic_status got done %b busy %b count %0d want done 1 busy 0 count 2",
               bus.done_out, bus.busy_out, bus.word_count_out);
    end
  endtask

  task automatic test_flush();
    logic [31:0] exp_d[2];
    exp_d[0] = 32'hA3A2A1A0;
    exp_d[1] = 32'h0000A5A4;
    clear_logs();
    arm();
    run_frame(8'hA0, 6, 1'b0);
    checks++;
    if (wa.size() != 2) begin
      errors++;
      $display("FAIL flush_nwrites got %0d want 2", wa.size());
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (k >= wa.size()) begin
        errors++;
        $display("FAIL flush_write%0d missing want data %h", k, exp_d[k]);
      end else if (wa[k] !== 16'(k) || wd[k] !== exp_d[k]) begin
        errors++;
        $display("FAIL flush_write%0d got addr %0d data %h want addr %0d data %h",
                 k, wa[k], wd[k], k, exp_d[k]);
      end
    end
    checks++;
    if (bus.done_out !== 1'b1 || bus.word_count_out !== 16'd2) begin
      errors++;
      $display("FAIL flush_status got done %b count %0d want done 1 count 2",
               bus.done_out, bus.word_count_out);
    end
  endtask

  task automatic test_skip_running_frame();
    clear_logs();
    @(negedge clk);
    frame_valid   = 1'b1;
    capture_start = 1'b1;
    @(negedge clk);
    capture_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pixel_valid = 1'b1;
      pixel_data  = 8'hC0 + 8'(i);
    end
    @(negedge clk);
    pixel_valid = 1'b0;
    frame_valid = 1'b0;
    idle(2);
    checks++;
    if (wa.size() != 0 || bus.busy_out !== 1'b1) begin
      errors++;
      $display("FAIL skip_running got writes %0d busy %b want writes 0 busy 1",
               wa.size(), bus.busy_out);
    end
    run_frame(8'h11, 4, 1'b0);
    checks++;
    if (wa.size() != 1) begin
      errors++;
      $display("FAIL skip_next_nwrites got %0d want 1", wa.size());
    end else if (wa[0] !== 16'd0 || wd[0] !== 32'h14131211) begin
      errors++;
      $display("FAIL skip_next_write got addr %0d data %h want addr 0 data 14131211",
               wa[0], wd[0]);
    end
  endtask

  task automatic test_capacity();
    logic [31:0] exp_d[4];
    exp_d[0] = 32'h33323130;
    exp_d[1] = 32'h37363534;
    exp_d[2] = 32'h3B3A3938;
    exp_d[3] = 32'h3F3E3D3C;
    clear_logs();
    arm();
    run_frame(8'h30, 24, 1'b0);
    checks++;
    if (sa.size() != 4) begin
      errors++;
      $display("FAIL cap_nwrites got %0d want 4", sa.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= sa.size()) begin
        errors++;
        $display("FAIL cap_write%0d missing want data %h", k, exp_d[k]);
      end else if (sa[k] !== 16'(k) || sd[k] !== exp_d[k]) begin
        errors++;
        $display("FAIL cap_write%0d got addr %0d data %h want addr %0d data %h",
                 k, sa[k], sd[k], k, exp_d[k]);
      end
    end
    checks++;
    if (sbus.overflow_out !== 1'b1 || sbus.word_count_out !== 16'd4 ||
        sbus.done_out !== 1'b1) begin
      errors++;
      $display("FAIL cap_status got ovf %b count %0d done %b want ovf 1 count 4 done 1",
               sbus.overflow_out, sbus.word_count_out, sbus.done_out);
    end
    checks++;
    if (bus.overflow_out !== 1'b0 || bus.word_count_out !== 16'd6 || wa.size() != 6) begin
      errors++;
      $display("FAIL cap_fullsize got ovf %b count %0d writes %0d want ovf 0 count 6 writes 6",
               bus.overflow_out, bus.word_count_out, wa.size());
    end else if (wa[5] !== 16'd5 || wd[5] !== 32'h47464544) begin
      errors++;
      $display("FAIL cap_fullsize_last got addr %0d data %h want addr 5 data 47464544",
               wa[5], wd[5]);
    end
  endtask

  task automatic test_gaps();
    logic [31:0] exp_d[2];
    exp_d[0] = 32'h04030201;
    exp_d[1] = 32'h08070605;
    clear_logs();
    arm();
    checks++;
    if (sbus.overflow_out !== 1'b0 || sbus.word_count_out !== 16'd0) begin
      errors++;
      $display("FAIL rearm_clear got ovf %b count %0d want ovf 0 count 0",
               sbus.overflow_out, sbus.word_count_out);
    end
    run_frame(8'h01, 8, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (k >= wa.size() || k >= p4.size()) begin
        errors++;
        $display("FAIL gaps_write%0d missing want data %h", k, exp_d[k]);
      end else if (wa[k] !== 16'(k) || wd[k] !== exp_d[k] || we[k] != p4[k] + 1) begin
        errors++;
        $display("FAIL gaps_write%0d got addr %0d data %h edge %0d want addr %0d data %h edge %0d",
                 k, wa[k], wd[k], we[k], k, exp_d[k], p4[k] + 1);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_logs();
    arm();
    @(negedge clk);
    frame_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pixel_valid = 1'b1;
      pixel_data  = 8'h61 + 8'(i);
    end
    @(negedge clk);
    pixel_valid = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (wa.size() != 1) begin
      errors++;
      $display("FAIL midrst_prewrite got %0d writes want 1", wa.size());
    end
    checks++;
    if ({bus.wr_en_out, bus.busy_out, bus.done_out, bus.overflow_out} !== 4'b0000 ||
        {bus.wr_addr_out, bus.wr_data_out, bus.word_count_out} !== 64'h0) begin
      errors++;
      $display("FAIL midrst_outputs got en %b busy %b done %b ovf %b addr %h data %h cnt %h want 0",
               bus.wr_en_out, bus.busy_out, bus.done_out, bus.overflow_out,
               bus.wr_addr_out, bus.wr_data_out, bus.word_count_out);
    end
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pixel_valid = 1'b1;
      pixel_data  = 8'h70 + 8'(i);
    end
    @(negedge clk);
    pixel_valid = 1'b0;
    frame_valid = 1'b0;
    idle(3);
    checks++;
    if (wa.size() != 0 || bus.busy_out !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle got writes %0d busy %b want writes 0 busy 0",
               wa.size(), bus.busy_out);
    end
    arm();
    run_frame(8'h51, 4, 1'b0);
    checks++;
    if (wa.size() != 1 || bus.word_count_out !== 16'd1) begin
      errors++;
      $display("FAIL midrst_recapture got writes %0d count %0d want writes 1 count 1",
               wa.size(), bus.word_count_out);
    end else if (wa[0] !== 16'd0 || wd[0] !== 32'h54535251) begin
      errors++;
      $display("FAIL midrst_recapture_write got addr %0d data %h want addr 0 data 54535251",
               wa[0], wd[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_skip_running_frame();
    test_capacity();
    test_gaps();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
